// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder: state encoding,
// default geometry, widths and the request address legality check.
package mem_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int CNT_W      = 3;
    localparam int DEPTH_DEF  = 64;
    localparam int RD_LAT_DEF = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_DONE = 3'd2,
        WR_DONE = 3'd3,
        ERR     = 3'd4
    } state_e;

    // A request is legal only when word aligned and inside the stored range.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a, input int unsigned depth);
        return (a[1:0] == 2'b00) && (a < ADDR_W'(depth * 32'd4));
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word-indexed storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int IDX_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/memory_responder.sv
// Single-outstanding memory responder: accepts one request from IDLE and
// answers with a ready or err pulse after a fixed latency.
module memory_responder
    import mem_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              memWriteOrRead,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              err,
    output logic              busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e            state_r;
    state_e            state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic [IDX_W-1:0]  idx_r;
    logic [IDX_W-1:0]  idx_in_s;
    logic              accept_s;
    logic              addr_ok_s;
    logic              mem_we_s;
    logic [DATA_W-1:0] mem_rdata_s;

    assign accept_s  = (state_r == IDLE) && req;
    assign addr_ok_s = addr_ok(addr, DEPTH);
    assign idx_in_s  = addr[IDX_W+1:2];
    // The write commits on the acceptance edge, so only the read index must outlive it.
    assign mem_we_s  = accept_s && memWriteOrRead && addr_ok_s;

    mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (idx_in_s),
        .wdata (wdata),
        .raddr (idx_r),
        .rdata (mem_rdata_s)
    );

    // Control state: FSM state and read latency counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Captured word index for the read in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_r <= {IDX_W{1'b0}};
        end else if (accept_s) begin
            idx_r <= idx_in_s;
        end else begin
            idx_r <= idx_r;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (req) begin
                    if (!addr_ok_s) begin
                        state_nxt_s = ERR;
                    end else if (memWriteOrRead) begin
                        state_nxt_s = WR_DONE;
                    end else begin
                        cnt_nxt_s = CNT_W'(RD_LAT - 1);
                        if (RD_LAT == 1) begin
                            state_nxt_s = RD_DONE;
                        end else begin
                            state_nxt_s = RD_WAIT;
                        end
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RD_WAIT: begin
                cnt_nxt_s = cnt_r - 3'd1;
                // <= rather than == so a corrupted zero count cannot wedge the FSM.
                if (cnt_r <= 3'd1) begin
                    state_nxt_s = RD_DONE;
                end else begin
                    state_nxt_s = RD_WAIT;
                end
            end
            RD_DONE: state_nxt_s = IDLE;
            WR_DONE: state_nxt_s = IDLE;
            ERR:     state_nxt_s = IDLE;
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        ready = 1'b0;
        err   = 1'b0;
        busy  = 1'b1;
        rdata = {DATA_W{1'b0}};
        case (state_r)
            IDLE:    busy = 1'b0;
            RD_WAIT: busy = 1'b1;
            RD_DONE: begin
                ready = 1'b1;
                rdata = mem_rdata_s;
            end
            WR_DONE: ready = 1'b1;
            ERR:     err   = 1'b1;
            default: busy  = 1'b0;
        endcase
    end

endmodule
